// File: rtl/seq_detector_param.sv
// Mealy serial-pattern detector with a runtime-loadable pattern (1..PAT_W bits), overlap select,
// input-valid qualifier, registered match pulse and saturating match counter.
module seq_detector_param #(
   parameter int               PAT_W   = 5,
   parameter logic [PAT_W-1:0] DEF_PAT = 5'b11011,
   parameter int               CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         din,
   input  logic                         din_vld,
   input  logic                         cfg_load,
   input  logic [PAT_W-1:0]             cfg_pat,
   input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
   input  logic                         cfg_ovl,
   output logic                         match,
   output logic                         match_q,
   output logic [CNT_W-1:0]             match_cnt,
   output logic [$clog2(PAT_W+1)-1:0]   fill
);

   localparam int             LW      = $clog2(PAT_W + 1);
   localparam logic [LW-1:0]  LEN_MAX = LW'(PAT_W);

   logic [PAT_W-1:0] pat_q,  pat_d;
   logic [LW-1:0]    len_q,  len_d;
   logic             ovl_q,  ovl_d;
   logic [PAT_W-2:0] hist_q, hist_d;
   logic [LW-1:0]    fill_q, fill_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic             match_d;

   logic [PAT_W-1:0] window_s;
   logic [PAT_W-1:0] mask_s;
   logic             full_s;
   logic             hit_s;

   // Compare window: newest bit at bit0, only the low len bits participate.
   always_comb begin
      window_s = {hist_q, din};
      mask_s   = {PAT_W{1'b0}};
      for (int i = 0; i < PAT_W; i++) begin
         mask_s[i] = (LW'(i) < len_q);
      end
      full_s  = (fill_q == (len_q - LW'(1)));
      hit_s   = (((window_s ^ pat_q) & mask_s) == {PAT_W{1'b0}});
      match_d = rst_n & din_vld & ~cfg_load & full_s & hit_s;
   end

   // Next-state: config load has priority over data; history only moves on valid bits.
   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      if (cfg_load) begin
         pat_d = cfg_pat;
         ovl_d = cfg_ovl;
         if ((cfg_len == {LW{1'b0}}) || (cfg_len > LEN_MAX)) begin
            len_d = LEN_MAX;
         end else begin
            len_d = cfg_len;
         end
         fill_d = {LW{1'b0}};
         cnt_d  = {CNT_W{1'b0}};
      end else begin
         if (din_vld) begin
            hist_d = window_s[PAT_W-2:0];
            if (match_d && !ovl_q) begin
               fill_d = {LW{1'b0}};
            end else if (full_s) begin
               fill_d = fill_q;
            end else begin
               fill_d = fill_q + LW'(1);
            end
         end else begin
            hist_d = hist_q;
            fill_d = fill_q;
         end
         if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   // State registers; reset restores the default pattern in non-overlapping mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q   <= DEF_PAT;
         len_q   <= LEN_MAX;
         ovl_q   <= 1'b0;
         hist_q  <= {(PAT_W-1){1'b0}};
         fill_q  <= {LW{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         match_q <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
      end
   end

   assign match     = match_d;
   assign match_cnt = cnt_q;
   assign fill      = fill_q;

endmodule
